// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
//
// Two-requester round-robin arbiter that owns the select of a shared 2:1
// data mux and sequences whole packets from the two producers onto a single
// downstream channel. A grant is held until the packet's last beat is
// accepted, until MAX_BEATS beats have gone through (forced release), or
// until the granted requester drops its request (abort). Every grant is
// followed by exactly one IDLE cycle in which the next owner is chosen.
//
// Parameters
//   W          data width of each requester and of the output
//   MAX_BEATS  maximum beats per grant before forced release (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req0/1     requester has a beat valid
//   data0/1    requester beat data
//   last0/1    requester beat ends its packet
//   ack0/1     requester beat accepted this cycle (combinational)
//   gnt0/1     requester holds the grant (registered)
//   sel        mux select, 0 = requester 0, 1 = requester 1 (registered)
//   out_valid  output beat valid (combinational from req and state)
//   out_data   output beat data = sel ? data1 : data0
//   out_last   output beat ends the grant
//   out_ready  consumer accepts the beat
// ---------------------------------------------------------------------------
module mux_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0,
    input  logic [W-1:0] data0,
    input  logic         last0,
    output logic         ack0,

    input  logic         req1,
    input  logic [W-1:0] data1,
    input  logic         last1,
    output logic         ack1,

    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,

    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    // Count value of the final beat a single grant may carry.
    localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

    state_t      state_q,      state_d;
    logic        sel_q,        sel_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  beat_cnt_q,   beat_cnt_d;
    logic        gnt0_q,       gnt1_q;

    // Signals describing the current owner; only meaningful outside IDLE.
    logic        granted;
    logic        owner;
    logic        owner_req;
    logic        owner_last;
    logic        limit_hit;
    logic        xfer;

    // -----------------------------------------------------------------------
    // Output path: everything here depends on the registered state/sel and
    // the requester inputs. out_ready only reaches the acks, never out_valid.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path can leave it unassigned and infer a latch.
        granted    = 1'b0;
        owner      = 1'b0;
        owner_req  = 1'b0;
        owner_last = 1'b0;
        limit_hit  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;

        if (state_q != IDLE) begin
            granted    = 1'b1;
            owner      = (state_q == G1);
            owner_req  = owner ? req1  : req0;
            owner_last = owner ? last1 : last0;
            limit_hit  = (beat_cnt_q == LAST_CNT);
            out_valid  = owner_req;
            // A beat that reaches the limit closes the grant even if the
            // requester's packet continues; its remaining beats re-arbitrate.
            out_last   = owner_last | limit_hit;
            ack0       = (state_q == G0) & req0 & out_ready;
            ack1       = (state_q == G1) & req1 & out_ready;
        end
    end

    assign xfer     = out_valid & out_ready;
    assign out_data = sel_q ? data1 : data0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;

        unique case (state_q)
            IDLE: begin
                // With both requesting, the one that did not own the last
                // grant wins; a lone requester wins outright.
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d    = G0;
                    sel_d      = 1'b0;
                    beat_cnt_d = 8'd0;
                end else if (req1) begin
                    state_d    = G1;
                    sel_d      = 1'b1;
                    beat_cnt_d = 8'd0;
                end
            end

            G0, G1: begin
                if (!owner_req) begin
                    // Requester withdrew mid-grant: release without a beat so
                    // the arbiter recovers from the protocol violation.
                    state_d      = IDLE;
                    last_grant_d = owner;
                    beat_cnt_d   = 8'd0;
                end else if (xfer) begin
                    if (out_last) begin
                        state_d      = IDLE;
                        last_grant_d = owner;
                        beat_cnt_d   = 8'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
                // A stalled beat (out_ready low) leaves everything unchanged.
            end

            default: begin
                state_d    = IDLE;
                beat_cnt_d = 8'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. The grant flags are registered copies of the decoded
    // next state so gnt0/gnt1 come straight from flops.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            gnt0_q       <= (state_d == G0);
            gnt1_q       <= (state_d == G1);
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign sel  = sel_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter
//
// Directed scenarios with literal expectations, followed by randomized
// traffic. A packet-level model (who owns the channel, how many beats it
// has sent, who owned it last) predicts every output and is compared on
// each falling clock edge.
// ---------------------------------------------------------------------------
module tb_mux_arbiter;

    localparam int W         = 8;
    localparam int MAX_BEATS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         last0 = 1'b0, last1 = 1'b0;
    logic         ack0, ack1, gnt0, gnt1, sel;
    logic         out_valid, out_last;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mux_arbiter #(.W(W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .data0     (data0),
        .last0     (last0),
        .ack0      (ack0),
        .req1      (req1),
        .data1     (data1),
        .last1     (last1),
        .ack1      (ack1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_owner = -1;   // -1 = nobody, else requester index
    int   m_beats = 0;    // beats already sent in the current grant
    logic m_sel   = 1'b0;
    logic m_lg    = 1'b1; // requester that owned the previous grant

    function automatic logic m_req();
        return (m_owner == 0) ? req0 : (m_owner == 1) ? req1 : 1'b0;
    endfunction

    function automatic logic m_last();
        if (m_owner < 0) return 1'b0;
        return ((m_owner == 0) ? last0 : last1) || (m_beats == MAX_BEATS - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_beats <= 0;
            m_sel   <= 1'b0;
            m_lg    <= 1'b1;
        end else if (m_owner < 0) begin
            if (req0 && req1) begin
                m_owner <= m_lg ? 0 : 1;
                m_sel   <= ~m_lg;
                m_beats <= 0;
            end else if (req0 || req1) begin
                m_owner <= req1 ? 1 : 0;
                m_sel   <= req1;
                m_beats <= 0;
            end
        end else if (!m_req() || (out_ready && m_last())) begin
            m_lg    <= (m_owner == 1);
            m_owner <= -1;
            m_beats <= 0;
        end else if (out_ready) begin
            m_beats <= m_beats + 1;
        end
    end

    always @(negedge clk) begin
        check("gnt0",      gnt0,      m_owner == 0);
        check("gnt1",      gnt1,      m_owner == 1);
        check("sel",       sel,       m_sel);
        check("out_valid", out_valid, m_req());
        check("out_last",  out_last,  m_last());
        check("out_data",  out_data,  m_sel ? data1 : data0);
        check("ack0",      ack0,      (m_owner == 0) && req0 && out_ready);
        check("ack1",      ack1,      (m_owner == 1) && req1 && out_ready);
    end

    // ---------------- transfer monitor ----------------
    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic         s;
        int           c;
    } xfer_t;

    xfer_t xfers[$];
    int    cyc    = 0;
    int    n_ack0 = 0;
    int    n_ack1 = 0;
    logic  ack_seen0 = 1'b0;
    logic  ack_seen1 = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && out_valid && out_ready)
            xfers.push_back('{d: out_data, l: out_last, s: sel, c: cyc});
        if (rst_n && ack0) n_ack0 <= n_ack0 + 1;
        if (rst_n && ack1) n_ack1 <= n_ack1 + 1;
        ack_seen0 <= rst_n && ack0;
        ack_seen1 <= rst_n && ack1;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        req0  = 1'b0;
        req1  = 1'b0;
        last0 = 1'b0;
        last1 = 1'b0;
        repeat (3) tick();
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t q0[$], q1[$];

    initial begin
        logic [1:0]   rr_exp [6];
        logic [W-1:0] bp_data [3];
        logic         bp_rdy [5];
        int           base;
        int           idx;
        int           n_rand_xfers;

        rr_exp  = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        bp_data = '{8'h11, 8'h22, 8'h33};
        bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // ---- reset and first grant ----
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_gnt0",      gnt0,      1'b0);
        check("rst_gnt1",      gnt1,      1'b0);
        check("rst_sel",       sel,       1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last",  out_last,  1'b0);
        check("rst_acks",      {ack1, ack0}, 2'b00);
        rst_n = 1'b1;
        tick();
        req0 = 1'b1; data0 = 8'hA5; last0 = 1'b1; out_ready = 1'b1;
        tick();
        check("first_gnt0",     gnt0,      1'b1);
        check("first_out_data", out_data,  8'hA5);
        check("first_out_last", out_last,  1'b1);
        check("first_ack0",     ack0,      1'b1);
        tick();
        check("first_release",  {gnt1, gnt0}, 2'b00);
        req0 = 1'b0;
        tick();

        // ---- round-robin with both requesting 1-beat packets ----
        req0 = 1'b1; last0 = 1'b1; data0 = 8'h0A;
        req1 = 1'b1; last1 = 1'b1; data1 = 8'h1B;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_gnt_%0d", i), {gnt1, gnt0}, rr_exp[i]);
        end
        idle_gap();

        // ---- forced release: 6 beats of one long packet from requester 1 ----
        xfers.delete();
        base = n_ack1;
        req1 = 1'b1; last1 = 1'b0; data1 = 8'h01; out_ready = 1'b1;
        for (int i = 0; i < 40 && (n_ack1 - base) < 6; i++) begin
            tick();
            if ((n_ack1 - base) < 6) data1 = 8'(n_ack1 - base + 1);
        end
        req1 = 1'b0;
        check("fr_count", xfers.size(), 6);
        if (xfers.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("fr_data_%0d", i), xfers[i].d, 8'(i + 1));
                check($sformatf("fr_last_%0d", i), xfers[i].l, (i == 3));
            end
            check("fr_bubble", xfers[4].c - xfers[3].c, 2);
        end
        idle_gap();

        // ---- abort: requester 0 withdraws before any beat ----
        req0 = 1'b1; data0 = 8'h3C; last0 = 1'b0; out_ready = 1'b0;
        tick();
        check("ab_gnt0", gnt0, 1'b1);
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h77; last1 = 1'b0;
        #1;
        check("ab_valid", out_valid, 1'b0);
        check("ab_ack0",  ack0,      1'b0);
        tick();
        check("ab_idle", {gnt1, gnt0}, 2'b00);
        req0 = 1'b1;
        tick();
        // Both pending; requester 0 owned the aborted grant, so 1 wins.
        check("ab_rr_gnt", {gnt1, gnt0}, 2'b10);
        out_ready = 1'b1; last1 = 1'b1;
        #1;
        check("ab_ack1",  ack1,     1'b1);
        check("ab_data1", out_data, 8'h77);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        idle_gap();

        // ---- backpressure: 3-beat packet with out_ready 1,0,0,1,1 ----
        xfers.delete();
        base = n_ack0;
        out_ready = 1'b0;
        req0 = 1'b1; data0 = bp_data[0]; last0 = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            idx = n_ack0 - base;
            if (idx < 3) begin
                data0 = bp_data[idx];
                last0 = (idx == 2);
            end else begin
                req0 = 1'b0;
            end
            out_ready = bp_rdy[i];
            #1;
            check($sformatf("bp_gnt0_%0d", i), gnt0, 1'b1);
            check($sformatf("bp_sel_%0d", i),  sel,  1'b0);
            tick();
        end
        req0 = 1'b0;
        check("bp_count", xfers.size(), 3);
        if (xfers.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_data_%0d", i), xfers[i].d, bp_data[i]);
                check($sformatf("bp_last_%0d", i), xfers[i].l, (i == 2));
            end
        end
        idle_gap();

        // ---- mid-packet reset ----
        out_ready = 1'b1;
        req0 = 1'b1; data0 = 8'h44; last0 = 1'b0;
        tick();
        tick();
        data0 = 8'h55;
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_gnt0",  gnt0,      1'b0);
        check("mr_valid", out_valid, 1'b0);
        check("mr_ack0",  ack0,      1'b0);
        req1 = 1'b1; data1 = 8'h66;
        tick();
        rst_n = 1'b1;
        tick();
        // Reset restores last_grant=1, so requester 0 wins the tie.
        check("mr_regrant", {gnt1, gnt0}, 2'b01);
        idle_gap();

        // ---- randomized traffic ----
        base = xfers.size();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (ack_seen0 && q0.size() > 0) void'(q0.pop_front());
            if (ack_seen1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) begin
                idx = $urandom_range(1, 6);
                for (int b = 0; b < idx; b++)
                    q0.push_back('{d: 8'($urandom), l: (b == idx - 1)});
            end
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) begin
                idx = $urandom_range(1, 6);
                for (int b = 0; b < idx; b++)
                    q1.push_back('{d: 8'($urandom), l: (b == idx - 1)});
            end
            req0 = (q0.size() > 0);
            if (req0) begin data0 = q0[0].d; last0 = q0[0].l; end
            else      begin data0 = 8'($urandom); last0 = 1'b0; end
            req1 = (q1.size() > 0);
            if (req1) begin data1 = q1[0].d; last1 = q1[0].l; end
            else      begin data1 = 8'($urandom); last1 = 1'b0; end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        n_rand_xfers = xfers.size() - base;
        check("rand_progress", (n_rand_xfers > 300), 1'b1);
        idle_gap();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns the select of the shared 2:1 data mux and sequences packets through it onto a single output channel. Each requester presents beats with a valid/last handshake. The arbiter grants one requester at a time, steers the mux to it, and holds the grant until that packet's last beat is accepted or a beat limit forces release. It sits between the two producer blocks and the single downstream consumer.

## Interface
Parameters:
- W, 8, data width of each requester and of the output
- MAX_BEATS, 4, maximum beats per grant before forced release; range 1..255

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assertion, active-low
- req0  in  1  requester 0 has a beat valid
- data0  in  W  requester 0 beat data
- last0  in  1  requester 0 beat is the end of its packet
- ack0  out  1  requester 0 beat accepted this cycle
- req1, data1, last1, ack1  same as above, for requester 1
- gnt0  out  1  requester 0 holds the grant (registered)
- gnt1  out  1  requester 1 holds the grant (registered)
- sel  out  1  mux select: 0 = requester 0, 1 = requester 1 (registered)
- out_valid  out  1  output beat valid
- out_data  out  W  output beat data = sel ? data1 : data0
- out_last  out  1  output beat ends the grant
- out_ready  in  1  consumer accepts beat

## Operation
- States: IDLE, G0, G1. Registers: state, sel, last_grant (1 bit), beat_cnt (8 bits).
- IDLE:
  - out_valid=0, ack0=ack1=0.
  - req0 only → G0. req1 only → G1.
  - Both requests → grant the requester not equal to last_grant.
  - Neither → stay in IDLE.
  - Entering Gx sets sel=x and beat_cnt=0.
- Gx:
  - gntx=1, out_valid=reqx, out_data per sel.
  - out_last = lastx | (beat_cnt == MAX_BEATS-1).
  - ackx = reqx & out_ready. The other ack is 0.
- Beat transfer happens when out_valid & out_ready.
  - Without out_last: beat_cnt increments.
  - With out_last: go to IDLE next cycle, last_grant=x, beat_cnt=0.
- Forced release: the beat at beat_cnt = MAX_BEATS-1 carries out_last=1 even if lastx=0. The requester's remaining beats re-arbitrate as a new packet.
- Abort: if reqx=0 in Gx, go to IDLE next cycle with last_grant=x and no beat transferred. This is a protocol violation but must be recoverable.
- sel changes only on the IDLE→Gx transition. It is stable throughout a grant and is retained in IDLE.
- Requester rule: reqx, datax and lastx stay stable until ackx. The arbiter does not check this.

## Timing
- Reset values: state=IDLE, gnt0=gnt1=0, sel=0, last_grant=1, beat_cnt=0. Therefore out_valid=0, ack0=ack1=0, out_last=0.
- Reset is asynchronous. Asserting it mid-packet drops the grant immediately. The in-flight beat is not acked.
- Grant latency: a request sampled in IDLE at edge N produces gntx=1 after edge N. The first beat can transfer in that same cycle.
- Within a grant: one beat per cycle while out_ready=1. out_ready=0 stalls the beat with no state change.
- Release: the last beat is accepted at edge M, so the state is IDLE during cycle M+1. Exactly one bubble cycle separates grants.
- Simultaneous events: a new request arriving in the same cycle as the last beat is only considered in IDLE. Round-robin then uses the updated last_grant.
- Output path: out_valid, out_data, out_last and ackx are combinational from the inputs and the registered state/sel. There is no combinational path from out_ready to out_valid.

## Test plan
- Reset and first grant: hold rst_n=0, then release. Check all outputs are 0 and sel=0. Assert req0 with data0=8'hA5, last0=1, out_ready=1 → gnt0=1 next cycle, out_data=8'hA5, out_last=1, ack0=1, then IDLE.
- Round-robin: hold req0 and req1 high, each sending 1-beat packets with out_ready=1. Grants must alternate G0, G1, G0, G1, with one IDLE cycle between each.
- Forced release (MAX_BEATS=4): req1 streams bytes 8'h01..8'h06 with last1=0. Out_last=1 must appear on beat 8'h04. Then IDLE, then G1 again; beat 8'h05 is the first beat of the new packet.
- Backpressure: a 3-beat packet from req0 with out_ready toggling 1,0,0,1,1. Expect exactly 3 transfers with no duplicated or dropped data. sel and gnt0 must stay stable throughout.
- Abort: in G0, drop req0 before any ack → IDLE next cycle. If req1 is pending, G1 follows and last_grant=0.
- Mid-packet reset: pull rst_n low during beat 2 of 3 → gnt0, out_valid and ack0 drop to 0 immediately. After release, arbitration restarts with req0 priority.
